// File: rtl/alu_issue_stage_if.sv
//------------------------------------------------------------------------------
// alu_issue_stage_if : decode-side, forwarding and execute-side signals of the
// ALU issue stage.  Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface alu_issue_stage_if #(
   parameter int DW = 16,
   parameter int RW = 3
);
   logic          flush;
   logic          in_valid;
   logic          in_ready;
   logic [2:0]    in_ctrl;
   logic [RW-1:0] in_rd;
   logic [RW-1:0] in_rs1;
   logic [RW-1:0] in_rs2;
   logic [DW-1:0] in_rs1_data;
   logic [DW-1:0] in_rs2_data;
   logic [DW-1:0] in_imm;
   logic          in_use_imm;
   logic          ex_fwd_en;
   logic [RW-1:0] ex_fwd_rd;
   logic [DW-1:0] ex_fwd_data;
   logic          wb_fwd_en;
   logic [RW-1:0] wb_fwd_rd;
   logic [DW-1:0] wb_fwd_data;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] alu_a;
   logic [DW-1:0] alu_b;
   logic [2:0]    alu_ctrl;
   logic [RW-1:0] out_rd;
   logic          illegal_op;

   modport master (
      output flush, in_valid, in_ctrl, in_rd, in_rs1, in_rs2, in_rs1_data,
             in_rs2_data, in_imm, in_use_imm, ex_fwd_en, ex_fwd_rd, ex_fwd_data,
             wb_fwd_en, wb_fwd_rd, wb_fwd_data, out_ready,
      input  in_ready, out_valid, alu_a, alu_b, alu_ctrl, out_rd, illegal_op
   );

   modport slave (
      input  flush, in_valid, in_ctrl, in_rd, in_rs1, in_rs2, in_rs1_data,
             in_rs2_data, in_imm, in_use_imm, ex_fwd_en, ex_fwd_rd, ex_fwd_data,
             wb_fwd_en, wb_fwd_rd, wb_fwd_data, out_ready,
      output in_ready, out_valid, alu_a, alu_b, alu_ctrl, out_rd, illegal_op
   );
endinterface

`default_nettype wire

// File: rtl/alu_issue_stage.sv
//------------------------------------------------------------------------------
// alu_issue_stage : ID/EX operand-forwarding issue register with a 2-entry
// skid buffer in front of the 16-bit ALU.  Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

module alu_issue_stage #(
   parameter int DW = 16,
   parameter int RW = 3
) (
   input  wire logic          clk,
   input  wire logic          rst_n,
   alu_issue_stage_if.slave   bus
);
   localparam logic [2:0] c_OP_MUL = 3'b001;
   localparam logic [2:0] c_OP_SHL = 3'b010;
   localparam logic [2:0] c_OP_XOR = 3'b011;
   localparam logic [2:0] c_OP_ADD = 3'b100;

   logic          r_main_valid, r_skid_valid, r_illegal;
   logic [DW-1:0] r_main_a, r_main_b, r_skid_a, r_skid_b;
   logic [2:0]    r_main_ctrl, r_skid_ctrl;
   logic [RW-1:0] r_main_rd, r_main_rs1, r_main_rs2;
   logic [RW-1:0] r_skid_rd, r_skid_rs1, r_skid_rs2;

   logic          w_ex_en, w_wb_en;
   logic [RW-1:0] w_ex_rd, w_wb_rd;
   logic [DW-1:0] w_ex_data, w_wb_data;

   assign w_ex_en   = bus.ex_fwd_en;
   assign w_ex_rd   = bus.ex_fwd_rd;
   assign w_ex_data = bus.ex_fwd_data;
   assign w_wb_en   = bus.wb_fwd_en;
   assign w_wb_rd   = bus.wb_fwd_rd;
   assign w_wb_data = bus.wb_fwd_data;

   // EX beats WB; register 0 never matches a forward.
   function automatic logic [DW-1:0] fwd_sel(input logic [RW-1:0] rs,
                                             input logic [DW-1:0] base);
      fwd_sel = base;
      if (rs != '0) begin
         if (w_ex_en && (w_ex_rd == rs))
            fwd_sel = w_ex_data;
         else if (w_wb_en && (w_wb_rd == rs))
            fwd_sel = w_wb_data;
      end
   endfunction

   logic          w_accept, w_leave, w_bad_op;
   logic [DW-1:0] w_cap_a, w_cap_b;
   logic [RW-1:0] w_cap_rs2;
   logic [DW-1:0] w_main_a_snp, w_main_b_snp, w_skid_a_snp, w_skid_b_snp;

   assign w_accept = bus.in_valid & ~r_skid_valid;
   assign w_leave  = r_main_valid & bus.out_ready;
   assign w_bad_op = !(bus.in_ctrl inside {c_OP_MUL, c_OP_SHL, c_OP_XOR, c_OP_ADD});

   assign w_cap_a   = (bus.in_rs1 == '0) ? '0 : fwd_sel(bus.in_rs1, bus.in_rs1_data);
   assign w_cap_b   = bus.in_use_imm ? bus.in_imm :
                      (bus.in_rs2 == '0) ? '0 : fwd_sel(bus.in_rs2, bus.in_rs2_data);
   // An immediate B is tagged with source r0 so snooping can never overwrite it.
   assign w_cap_rs2 = bus.in_use_imm ? '0 : bus.in_rs2;

   assign w_main_a_snp = fwd_sel(r_main_rs1, r_main_a);
   assign w_main_b_snp = fwd_sel(r_main_rs2, r_main_b);
   assign w_skid_a_snp = fwd_sel(r_skid_rs1, r_skid_a);
   assign w_skid_b_snp = fwd_sel(r_skid_rs2, r_skid_b);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_main_valid <= 1'b0;
         r_skid_valid <= 1'b0;
         r_illegal    <= 1'b0;
         r_main_a     <= '0;
         r_main_b     <= '0;
         r_main_ctrl  <= '0;
         r_main_rd    <= '0;
         r_main_rs1   <= '0;
         r_main_rs2   <= '0;
         r_skid_a     <= '0;
         r_skid_b     <= '0;
         r_skid_ctrl  <= '0;
         r_skid_rd    <= '0;
         r_skid_rs1   <= '0;
         r_skid_rs2   <= '0;
      end else if (bus.flush) begin
         r_main_valid <= 1'b0;
         r_skid_valid <= 1'b0;
      end else begin
         if (!r_main_valid || w_leave) begin
            if (r_skid_valid) begin
               r_main_valid <= 1'b1;
               r_skid_valid <= 1'b0;
               r_main_a     <= w_skid_a_snp;
               r_main_b     <= w_skid_b_snp;
               r_main_ctrl  <= r_skid_ctrl;
               r_main_rd    <= r_skid_rd;
               r_main_rs1   <= r_skid_rs1;
               r_main_rs2   <= r_skid_rs2;
            end else if (w_accept) begin
               r_main_valid <= 1'b1;
               r_main_a     <= w_cap_a;
               r_main_b     <= w_cap_b;
               r_main_ctrl  <= bus.in_ctrl;
               r_main_rd    <= bus.in_rd;
               r_main_rs1   <= bus.in_rs1;
               r_main_rs2   <= w_cap_rs2;
            end else begin
               r_main_valid <= 1'b0;
            end
         end else begin
            r_main_a <= w_main_a_snp;
            r_main_b <= w_main_b_snp;
            if (w_accept) begin
               r_skid_valid <= 1'b1;
               r_skid_a     <= w_cap_a;
               r_skid_b     <= w_cap_b;
               r_skid_ctrl  <= bus.in_ctrl;
               r_skid_rd    <= bus.in_rd;
               r_skid_rs1   <= bus.in_rs1;
               r_skid_rs2   <= w_cap_rs2;
            end else begin
               r_skid_a <= w_skid_a_snp;
               r_skid_b <= w_skid_b_snp;
            end
         end
         if (w_accept && w_bad_op)
            r_illegal <= 1'b1;
      end
   end

   assign bus.in_ready   = ~r_skid_valid;
   assign bus.out_valid  = r_main_valid;
   assign bus.alu_a      = r_main_a;
   assign bus.alu_b      = r_main_b;
   assign bus.alu_ctrl   = r_main_ctrl;
   assign bus.out_rd     = r_main_rd;
   assign bus.illegal_op = r_illegal;

endmodule

`default_nettype wire

// File: tb/tb_alu_issue_stage.sv
//------------------------------------------------------------------------------
// tb_alu_issue_stage : directed and random checks of alu_issue_stage against a
// queue-based reference model.  Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_alu_issue_stage;
   localparam int DW = 16;
   localparam int RW = 3;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   alu_issue_stage_if #(.DW(DW), .RW(RW)) bus ();

   alu_issue_stage #(.DW(DW), .RW(RW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct {
      logic [DW-1:0] a;
      logic [DW-1:0] b;
      logic [2:0]    ctrl;
      logic [RW-1:0] rd;
      logic [RW-1:0] rs1;
      logic [RW-1:0] rs2;
      bit            imm;
   } ent_t;

   ent_t q[$];
   bit   m_ill;
   int   n_checks = 0;
   int   n_fail   = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [DW-1:0] fwd_val(input logic [RW-1:0] rs, input logic [DW-1:0] dflt);
      if (rs == 0) return dflt;
      if (bus.ex_fwd_en && bus.ex_fwd_rd == rs) return bus.ex_fwd_data;
      if (bus.wb_fwd_en && bus.wb_fwd_rd == rs) return bus.wb_fwd_data;
      return dflt;
   endfunction

   // Next-state of the model from the inputs currently applied.
   task automatic model_update();
      bit   leave, acc;
      ent_t e;
      if (!rst_n) begin
         q.delete();
         m_ill = 0;
      end else if (bus.flush) begin
         q.delete();
      end else begin
         leave = (q.size() > 0) && bus.out_ready;
         acc   = bus.in_valid && (q.size() < 2);
         if (leave) void'(q.pop_front());
         foreach (q[i]) begin
            q[i].a = fwd_val(q[i].rs1, q[i].a);
            if (!q[i].imm) q[i].b = fwd_val(q[i].rs2, q[i].b);
         end
         if (acc) begin
            e.a    = (bus.in_rs1 == 0) ? '0 : fwd_val(bus.in_rs1, bus.in_rs1_data);
            e.b    = bus.in_use_imm ? bus.in_imm :
                     (bus.in_rs2 == 0) ? '0 : fwd_val(bus.in_rs2, bus.in_rs2_data);
            e.ctrl = bus.in_ctrl;
            e.rd   = bus.in_rd;
            e.rs1  = bus.in_rs1;
            e.rs2  = bus.in_rs2;
            e.imm  = bus.in_use_imm;
            q.push_back(e);
            if (!(bus.in_ctrl inside {3'b001, 3'b010, 3'b011, 3'b100})) m_ill = 1;
         end
      end
   endtask

   task automatic compare();
      chk("out_valid", bus.out_valid, q.size() > 0);
      chk("in_ready", bus.in_ready, q.size() < 2);
      chk("illegal_op", bus.illegal_op, m_ill);
      if (q.size() > 0) begin
         chk("alu_a", bus.alu_a, q[0].a);
         chk("alu_b", bus.alu_b, q[0].b);
         chk("alu_ctrl", bus.alu_ctrl, q[0].ctrl);
         chk("out_rd", bus.out_rd, q[0].rd);
      end
   endtask

   task automatic step();
      model_update();
      @(posedge clk);
      #1;
      compare();
   endtask

   task automatic idle();
      bus.flush      = 0;
      bus.in_valid   = 0;
      bus.in_use_imm = 0;
      bus.in_imm     = '0;
      bus.ex_fwd_en  = 0;
      bus.ex_fwd_rd  = '0;
      bus.ex_fwd_data = '0;
      bus.wb_fwd_en  = 0;
      bus.wb_fwd_rd  = '0;
      bus.wb_fwd_data = '0;
   endtask

   task automatic send(input logic [2:0] ctrl, input logic [RW-1:0] rd,
                       input logic [RW-1:0] rs1, input logic [RW-1:0] rs2,
                       input logic [DW-1:0] d1, input logic [DW-1:0] d2);
      bus.in_valid    = 1;
      bus.in_ctrl     = ctrl;
      bus.in_rd       = rd;
      bus.in_rs1      = rs1;
      bus.in_rs2      = rs2;
      bus.in_rs1_data = d1;
      bus.in_rs2_data = d2;
   endtask

   initial begin
      idle();
      bus.out_ready = 1;
      send(3'b100, 3'd0, 3'd0, 3'd0, '0, '0);
      bus.in_valid = 0;

      // Reset state
      rst_n = 0;
      step();
      step();
      chk("rst_alu_a", bus.alu_a, 0);
      chk("rst_alu_b", bus.alu_b, 0);
      chk("rst_alu_ctrl", bus.alu_ctrl, 0);
      chk("rst_out_rd", bus.out_rd, 0);
      rst_n = 1;

      // Basic issue and streaming
      send(3'b100, 3'd5, 3'd1, 3'd2, 16'h0005, 16'h0003);
      step();
      chk("basic_a", bus.alu_a, 16'h0005);
      chk("basic_b", bus.alu_b, 16'h0003);
      chk("basic_ctrl", bus.alu_ctrl, 3'b100);
      for (int i = 0; i < 4; i++) begin
         send(3'b011, 3'(i + 1), 3'd1, 3'd2, 16'(i * 7), 16'(i * 3));
         step();
         chk("stream_valid", bus.out_valid, 1);
      end
      idle();
      step();

      // Forward priority and r0
      send(3'b100, 3'd1, 3'd3, 3'd2, 16'hAAAA, 16'h0007);
      bus.ex_fwd_en = 1; bus.ex_fwd_rd = 3; bus.ex_fwd_data = 16'h1111;
      bus.wb_fwd_en = 1; bus.wb_fwd_rd = 3; bus.wb_fwd_data = 16'h2222;
      step();
      chk("fwd_ex_prio", bus.alu_a, 16'h1111);
      idle();
      send(3'b100, 3'd1, 3'd0, 3'd2, 16'h5555, 16'h0007);
      bus.ex_fwd_en = 1; bus.ex_fwd_rd = 0; bus.ex_fwd_data = 16'h9999;
      step();
      chk("fwd_r0", bus.alu_a, 16'h0000);
      idle();
      step();

      // Back-pressure through the skid entry
      bus.out_ready = 0;
      send(3'b001, 3'd1, 3'd1, 3'd2, 16'h0010, 16'h0001);
      step();
      send(3'b010, 3'd2, 3'd1, 3'd2, 16'h0020, 16'h0002);
      step();
      chk("bp_in_ready", bus.in_ready, 0);
      chk("bp_hold_a", bus.alu_a, 16'h0010);
      idle();
      step();
      bus.out_ready = 1;
      step();
      chk("bp_second_a", bus.alu_a, 16'h0020);
      chk("bp_ready_back", bus.in_ready, 1);
      step();

      // Snooping while stalled, immediate immune to snoop
      bus.out_ready = 0;
      send(3'b100, 3'd6, 3'd1, 3'd4, 16'h0001, 16'h1234);
      step();
      idle();
      bus.wb_fwd_en = 1; bus.wb_fwd_rd = 4; bus.wb_fwd_data = 16'hBEEF;
      step();
      chk("snoop_b", bus.alu_b, 16'hBEEF);
      idle();
      bus.out_ready = 1;
      step();
      bus.out_ready = 0;
      send(3'b100, 3'd6, 3'd1, 3'd4, 16'h0001, 16'h1234);
      bus.in_use_imm = 1; bus.in_imm = 16'h0002;
      step();
      idle();
      bus.wb_fwd_en = 1; bus.wb_fwd_rd = 4; bus.wb_fwd_data = 16'h7777;
      bus.ex_fwd_en = 1; bus.ex_fwd_rd = 4; bus.ex_fwd_data = 16'h6666;
      step();
      chk("imm_b", bus.alu_b, 16'h0002);
      idle();
      bus.out_ready = 1;
      step();

      // Flush with both entries full and a same-cycle input
      bus.out_ready = 0;
      send(3'b100, 3'd1, 3'd1, 3'd2, 16'h0100, 16'h0200);
      step();
      step();
      bus.flush = 1;
      step();
      chk("flush_valid", bus.out_valid, 0);
      chk("flush_ready", bus.in_ready, 1);
      idle();
      bus.out_ready = 1;
      step();
      chk("flush_empty", bus.out_valid, 0);

      // Sticky illegal op and mid-stream reset
      send(3'b111, 3'd1, 3'd1, 3'd2, 16'h0001, 16'h0002);
      step();
      chk("illegal_set", bus.illegal_op, 1);
      chk("illegal_fwd_ctrl", bus.alu_ctrl, 3'b111);
      send(3'b011, 3'd1, 3'd1, 3'd2, 16'h0001, 16'h0002);
      step();
      chk("illegal_sticky", bus.illegal_op, 1);
      rst_n = 0;
      step();
      chk("midrst_valid", bus.out_valid, 0);
      chk("midrst_ctrl", bus.alu_ctrl, 0);
      chk("midrst_illegal", bus.illegal_op, 0);
      rst_n = 1;
      idle();
      step();

      // Random traffic
      for (int i = 0; i < 3000; i++) begin
         rst_n           = ($urandom_range(0, 149) != 0);
         bus.flush       = ($urandom_range(0, 24) == 0);
         bus.in_valid    = ($urandom_range(0, 9) < 7);
         bus.in_ctrl     = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 7))
                                                        : 3'($urandom_range(1, 4));
         bus.in_rd       = 3'($urandom_range(0, 7));
         bus.in_rs1      = 3'($urandom_range(0, 7));
         bus.in_rs2      = 3'($urandom_range(0, 7));
         bus.in_rs1_data = 16'($urandom);
         bus.in_rs2_data = 16'($urandom);
         bus.in_imm      = 16'($urandom);
         bus.in_use_imm  = ($urandom_range(0, 3) == 0);
         bus.ex_fwd_en   = ($urandom_range(0, 1) == 0);
         bus.ex_fwd_rd   = 3'($urandom_range(0, 7));
         bus.ex_fwd_data = 16'($urandom);
         bus.wb_fwd_en   = ($urandom_range(0, 1) == 0);
         bus.wb_fwd_rd   = 3'($urandom_range(0, 7));
         bus.wb_fwd_data = 16'($urandom);
         bus.out_ready   = ($urandom_range(0, 9) < 6);
         step();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

`default_nettype wire

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- ID/EX issue register directly upstream of the 16-bit ALU; drives its A, B and 3-bit ctrl inputs.
- Selects operands from the register file, an immediate, or forwarded results (EX and WB), then holds them in a 2-entry skid buffer with valid/ready handshakes on both sides.
- Decouples decode from execute so that execute back-pressure never creates a combinational path to decode.

Parameters:
- DW, 16, datapath width; must match the ALU A/B width.
- RW, 3, register address width (8 registers; r0 reads as zero).

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  synchronous, active-low reset
- flush  in  1  synchronous kill of all held entries
- in_valid  in  1  decode presents an instruction
- in_ready  out  1  stage can accept; registered
- in_ctrl  in  3  ALU op: 001 mul, 010 shl, 011 xor, 100 add
- in_rd  in  RW  destination register
- in_rs1, in_rs2  in  RW  source register addresses
- in_rs1_data, in_rs2_data  in  DW  register-file read data
- in_imm  in  DW  immediate
- in_use_imm  in  1  B = in_imm instead of rs2
- ex_fwd_en  in  1  EX result valid for forwarding
- ex_fwd_rd  in  RW  EX destination register
- ex_fwd_data  in  DW  EX result (ALU_result)
- wb_fwd_en  in  1  WB write valid
- wb_fwd_rd  in  RW  WB destination register
- wb_fwd_data  in  DW  WB write data
- out_valid  out  1  alu_a/alu_b/alu_ctrl/out_rd are valid
- out_ready  in  1  execute accepts this cycle
- alu_a, alu_b  out  DW  ALU operands
- alu_ctrl  out  3  ALU op
- out_rd  out  RW  destination carried to EX
- illegal_op  out  1  sticky: an accepted instruction had an undefined ctrl

Behaviour:
- Reset (rst_n=0 at edge):
  - main and skid entries invalid, so out_valid=0 and in_ready=1 after the edge.
  - alu_a, alu_b, out_rd = 0; alu_ctrl = 000; illegal_op = 0.
  - Inputs are ignored while rst_n=0.
- Acceptance:
  - An instruction is accepted when in_valid & in_ready.
  - in_ready = NOT skid_valid (registered).
  - Transfer out occurs when out_valid & out_ready.
- Operand resolution at capture, per source rsN, highest priority first:
  - rsN==0 -> 0
  - ex_fwd_en & ex_fwd_rd==rsN -> ex_fwd_data
  - wb_fwd_en & wb_fwd_rd==rsN -> wb_fwd_data
  - otherwise in_rsN_data
  - Forwarding never matches rd==0.
- B operand: in_use_imm=1 -> in_imm, and rs2 is marked "no source" so it is never updated by snooping.
- Snooping:
  - Each held entry keeps its rs1/rs2 addresses.
  - Every cycle a held entry that is not leaving updates its operand when a forward source matches, using the same priority as capture.
  - Held operands therefore never go stale.
- Skid buffer:
  - Main empty, or main leaving: an accepted instruction goes to main and appears on the outputs the next cycle (latency 1).
  - Main valid and not leaving, with acceptance: the instruction goes to skid, and in_ready=0 from the next cycle.
  - When main leaves and skid is valid, skid moves to main the same edge and skid_valid clears.
  - A simultaneous new acceptance is impossible because in_ready=0.
- Output stability: while out_valid & !out_ready, alu_a/alu_b/alu_ctrl/out_rd change only through snoop updates.
- Throughput: 1 instruction/cycle with out_ready held high.
- illegal_op:
  - Set when an accepted in_ctrl is not in {001, 010, 011, 100}.
  - The instruction is still forwarded unchanged.
  - Cleared only by reset.
- flush:
  - At the edge, main_valid and skid_valid clear and any same-cycle input is discarded.
  - out_valid=0 and in_ready=1 next cycle; data registers hold their values.
  - flush has priority over acceptance and transfer.
  - rst_n has priority over flush.
- Reset asserted mid-operation drops all held entries with no output transfer.

Test Plan:
- Reset, then in_valid: ctrl=100, rs1=1 (data 0x0005), rs2=2 (data 0x0003), out_ready=1 -> next cycle out_valid=1, alu_a=0x0005, alu_b=0x0003, alu_ctrl=100; sustained stream yields one output per cycle.
- Forward priority: rs1=3, ex_fwd(rd=3, 0x1111) and wb_fwd(rd=3, 0x2222) both asserted -> alu_a=0x1111; rs1=0 with ex_fwd_rd=0 -> alu_a=0x0000.
- Back-pressure: out_ready=0, accept I0 then I1 -> in_ready=0 after I1, outputs hold I0; raise out_ready -> I0 then I1 on consecutive cycles, and in_ready=1 one cycle after I0 leaves.
- Snoop while stalled: I0 rs2=4 held with out_ready=0, wb_fwd(rd=4, 0xBEEF) pulses -> alu_b=0xBEEF next cycle; in_use_imm=1 with imm=0x0002 -> alu_b stays 0x0002 under a matching forward.
- Flush with main and skid full plus in_valid the same cycle -> out_valid=0, in_ready=1 next cycle, no instruction emitted.
- in_ctrl=111 accepted -> illegal_op=1 and stays 1 through later legal ops; rst_n=0 mid-stream -> out_valid=0, alu_ctrl=000, illegal_op=0.
